// File: rtl/ase_hssi_loopback_emul.sv
// ASE HSSI loopback emulator: buffers whole AFU TX packets and replays them on the RX stream.
// Build macro HSSI_LB_MAC_SWAP_EN swaps DA/SA bytes on the first RX beat of each packet.
module ase_hssi_loopback_emul #(
   parameter int DATA_W     = 512,
   parameter int DEPTH      = 64,
   parameter int IPG_CYCLES = 2
) (
   input  logic                clk,
   input  logic                softReset,
   input  logic                tx_tvalid,
   output logic                tx_tready,
   input  logic [DATA_W-1:0]   tx_tdata,
   input  logic [DATA_W/8-1:0] tx_tkeep,
   input  logic                tx_tlast,
   input  logic                tx_tuser_err,
   input  logic                pause_req,
   output logic                rx_tvalid,
   output logic [DATA_W-1:0]   rx_tdata,
   output logic [DATA_W/8-1:0] rx_tkeep,
   output logic                rx_tlast,
   output logic [31:0]         pkt_fwd_cnt,
   output logic [31:0]         pkt_drop_cnt
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = AW + 1;
   localparam int ENT_W  = DATA_W + KEEP_W + 1;
   localparam int GW     = $clog2(IPG_CYCLES + 2);

   typedef enum logic {ACCEPT, DISCARD} in_state_t;
   typedef enum logic [1:0] {IDLE, SEND, GAP} out_state_t;

   function automatic logic [DATA_W-1:0] first_beat_data(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = d;
`ifdef HSSI_LB_MAC_SWAP_EN
      r[47:0]  = d[95:48];
      r[95:48] = d[47:0];
`endif
      return r;
   endfunction

   logic [ENT_W-1:0] mem_r [DEPTH];

   in_state_t        in_state_r,   in_state_s;
   out_state_t       out_state_r,  out_state_s;
   logic [PW-1:0]    wr_ptr_r,     wr_ptr_s;
   logic [PW-1:0]    commit_ptr_r, commit_ptr_s;
   logic [PW-1:0]    rd_ptr_r,     rd_ptr_s;
   logic [PW-1:0]    avail_r,      avail_s;
   logic [GW-1:0]    gap_cnt_r,    gap_cnt_s;

   logic             hs_s;
   logic             full_s;
   logic             wr_en_s;
   logic             commit_s;
   logic             drop_s;
   logic             done_s;
   logic             rd_en_s;
   logic             rd_first_s;
   logic [ENT_W-1:0] wr_ent_s;
   logic [ENT_W-1:0] rd_ent_s;

   assign hs_s     = tx_tvalid & tx_tready;
   assign full_s   = ((wr_ptr_r - rd_ptr_r) == PW'(DEPTH));
   assign wr_ent_s = {tx_tlast, tx_tkeep, tx_tdata};
   assign done_s   = rx_tvalid & rx_tlast;

   // Input side: write, commit or roll back the packet being received
   always_comb begin
      in_state_s   = in_state_r;
      wr_ptr_s     = wr_ptr_r;
      commit_ptr_s = commit_ptr_r;
      wr_en_s      = 1'b0;
      commit_s     = 1'b0;
      drop_s       = 1'b0;
      case (in_state_r)
         ACCEPT: begin
            if (!hs_s) begin
               in_state_s = ACCEPT;
            end else if (full_s) begin
               wr_ptr_s = commit_ptr_r;
               if (tx_tlast) begin
                  drop_s = 1'b1;
               end else begin
                  in_state_s = DISCARD;
               end
            end else if (tx_tlast && tx_tuser_err) begin
               wr_ptr_s = commit_ptr_r;
               drop_s   = 1'b1;
            end else begin
               wr_en_s  = 1'b1;
               wr_ptr_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
               if (tx_tlast) begin
                  commit_s     = 1'b1;
                  commit_ptr_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
               end else begin
                  commit_s = 1'b0;
               end
            end
         end
         DISCARD: begin
            if (hs_s && tx_tlast) begin
               drop_s     = 1'b1;
               in_state_s = ACCEPT;
            end else begin
               in_state_s = DISCARD;
            end
         end
         default: begin
            in_state_s = ACCEPT;
         end
      endcase
   end

   // pkt_avail after this cycle's commit and emitted-tlast, so a coincident pair cancels
   assign avail_s = avail_r + {{(PW-1){1'b0}}, commit_s} - {{(PW-1){1'b0}}, done_s};

   // Output side: schedule buffer reads, inter-packet gap and packet boundaries
   always_comb begin
      out_state_s = out_state_r;
      gap_cnt_s   = gap_cnt_r;
      rd_en_s     = 1'b0;
      rd_first_s  = 1'b0;
      case (out_state_r)
         IDLE: begin
            if (avail_r != {PW{1'b0}}) begin
               rd_en_s     = 1'b1;
               rd_first_s  = 1'b1;
               out_state_s = SEND;
            end else begin
               out_state_s = IDLE;
            end
         end
         SEND: begin
            if (!done_s) begin
               rd_en_s = 1'b1;
            end else if (IPG_CYCLES > 0) begin
               out_state_s = GAP;
               gap_cnt_s   = {GW{1'b0}};
            end else if (avail_s != {PW{1'b0}}) begin
               rd_en_s    = 1'b1;
               rd_first_s = 1'b1;
            end else begin
               out_state_s = IDLE;
            end
         end
         GAP: begin
            // The last gap cycle launches the next read so the gap is exactly IPG_CYCLES
            if (gap_cnt_r != GW'(IPG_CYCLES - 1)) begin
               gap_cnt_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
            end else if (avail_r != {PW{1'b0}}) begin
               rd_en_s     = 1'b1;
               rd_first_s  = 1'b1;
               out_state_s = SEND;
            end else begin
               out_state_s = IDLE;
            end
         end
         default: begin
            out_state_s = IDLE;
         end
      endcase
      rd_ptr_s = rd_ptr_r + {{(PW-1){1'b0}}, rd_en_s};
   end

   // Read port; forwards a same-cycle write so back-to-back replay never sees a stale entry
   always_comb begin
      if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0])) begin
         rd_ent_s = wr_ent_s;
      end else begin
         rd_ent_s = mem_r[rd_ptr_r[AW-1:0]];
      end
   end

   // Packet buffer storage
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_ent_s;
      end
   end

   // Pointer, FSM and counter state
   always_ff @(posedge clk or posedge softReset) begin
      if (softReset) begin
         in_state_r   <= ACCEPT;
         out_state_r  <= IDLE;
         wr_ptr_r     <= {PW{1'b0}};
         commit_ptr_r <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         avail_r      <= {PW{1'b0}};
         gap_cnt_r    <= {GW{1'b0}};
         tx_tready    <= 1'b0;
         pkt_fwd_cnt  <= 32'd0;
         pkt_drop_cnt <= 32'd0;
      end else begin
         in_state_r   <= in_state_s;
         out_state_r  <= out_state_s;
         wr_ptr_r     <= wr_ptr_s;
         commit_ptr_r <= commit_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         avail_r      <= avail_s;
         gap_cnt_r    <= gap_cnt_s;
         tx_tready    <= ~pause_req;
         pkt_fwd_cnt  <= pkt_fwd_cnt + {31'd0, commit_s};
         pkt_drop_cnt <= pkt_drop_cnt + {31'd0, drop_s};
      end
   end

   // RX beat register: loaded on each read, otherwise all-zero
   always_ff @(posedge clk or posedge softReset) begin
      if (softReset) begin
         rx_tvalid <= 1'b0;
         rx_tdata  <= {DATA_W{1'b0}};
         rx_tkeep  <= {KEEP_W{1'b0}};
         rx_tlast  <= 1'b0;
      end else if (rd_en_s) begin
         rx_tvalid <= 1'b1;
         rx_tdata  <= rd_first_s ? first_beat_data(rd_ent_s[DATA_W-1:0]) : rd_ent_s[DATA_W-1:0];
         rx_tkeep  <= rd_ent_s[DATA_W +: KEEP_W];
         rx_tlast  <= rd_ent_s[ENT_W-1];
      end else begin
         rx_tvalid <= 1'b0;
         rx_tdata  <= {DATA_W{1'b0}};
         rx_tkeep  <= {KEEP_W{1'b0}};
         rx_tlast  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ase_hssi_loopback_emul.sv
// Scoreboard bench for ase_hssi_loopback_emul: expected RX beats are queued at send time
// and popped by an independent monitor; HSSI_LB_MAC_SWAP_EN selects the expected first-beat swap.
module tb_ase_hssi_loopback_emul;
   localparam int DW    = 512;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 64;
   localparam int IPG   = 2;
   localparam int CW    = 640;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          softReset = 1'b1;
   logic          tx_tvalid = 1'b0;
   logic          tx_tready;
   logic [DW-1:0] tx_tdata = '0;
   logic [KW-1:0] tx_tkeep = '0;
   logic          tx_tlast = 1'b0;
   logic          tx_tuser_err = 1'b0;
   logic          pause_req = 1'b0;
   logic          rx_tvalid;
   logic [DW-1:0] rx_tdata;
   logic [KW-1:0] rx_tkeep;
   logic          rx_tlast;
   logic [31:0]   pkt_fwd_cnt;
   logic [31:0]   pkt_drop_cnt;

   ase_hssi_loopback_emul #(.DATA_W(DW), .DEPTH(DEPTH), .IPG_CYCLES(IPG)) dut (
      .clk(clk), .softReset(softReset),
      .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
      .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser_err(tx_tuser_err),
      .pause_req(pause_req),
      .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
      .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt)
   );

   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   beat_t exp_q[$];
   beat_t cur_pkt[$];
   int    gaps[$];
   int    fwd_exp = 0;
   int    drop_exp = 0;
   int    first_cyc = -1;
   int    tlast_cyc = -1;
   int    rdy_low_cnt = 0;
   bit    end_valid = 1'b0;
   int    end_cyc = 0;
   bit    rand_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] expect_first(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
`ifdef HSSI_LB_MAC_SWAP_EN
      for (int b = 0; b < 6; b++) begin
         r[b*8 +: 8]     = d[(b+6)*8 +: 8];
         r[(b+6)*8 +: 8] = d[b*8 +: 8];
      end
`endif
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic build_seq(input int len, input int base);
      beat_t b;
      cur_pkt.delete();
      for (int i = 0; i < len; i++) begin
         b.d = '0;
         b.d[31:0] = 32'(base + i);
         b.k = {KW{1'b1}};
         b.l = 1'b0;
         cur_pkt.push_back(b);
      end
   endtask

   task automatic build_rand(input int len);
      beat_t b;
      cur_pkt.delete();
      for (int i = 0; i < len; i++) begin
         b.d = rand_data();
         b.k = {$urandom, $urandom};
         b.l = 1'b0;
         cur_pkt.push_back(b);
      end
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit err);
      bit got;
      int guard;
      got = 1'b0;
      guard = 0;
      tx_tvalid = 1'b1;
      tx_tdata = d;
      tx_tkeep = k;
      tx_tlast = last;
      tx_tuser_err = err & last;
      while (!got) begin
         @(negedge clk);
         got = tx_tready;
         if (got && last) tlast_cyc = cyc;
         @(posedge clk);
         #1;
         guard++;
         if (!got && guard > 500) begin
            check("tx_handshake_timeout", CW'(tx_tready), CW'(1));
            got = 1'b1;
         end
      end
   endtask

   // Forwarded iff error-free and no longer than the buffer (bench sends long packets only into an empty buffer)
   task automatic send_pkt(input bit err);
      int    n;
      beat_t b;
      n = cur_pkt.size();
      if (!err && n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            b = cur_pkt[i];
            if (i == 0) b.d = expect_first(b.d);
            b.l = (i == n - 1);
            exp_q.push_back(b);
         end
         fwd_exp++;
      end else begin
         drop_exp++;
      end
      for (int i = 0; i < n; i++) drive_beat(cur_pkt[i].d, cur_pkt[i].k, i == n - 1, err);
      tx_tvalid = 1'b0;
      tx_tlast = 1'b0;
      tx_tuser_err = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rx_tvalid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (IPG + 3) @(posedge clk);
      #1;
      check("drain_queue_empty", CW'(exp_q.size()), CW'(0));
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_fwd_cnt"}, CW'(pkt_fwd_cnt), CW'(fwd_exp));
      check({tag, "_drop_cnt"}, CW'(pkt_drop_cnt), CW'(drop_exp));
   endtask

   // Monitor: tready timing, RX beat scoreboard, bubble and gap checks
   initial begin : monitor
      beat_t b;
      bit    in_pkt;
      bit    prev_pause;
      bit    prev_rst;
      logic  exp_rdy;
      in_pkt = 1'b0;
      prev_pause = 1'b0;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         if (softReset) begin
            in_pkt = 1'b0;
            end_valid = 1'b0;
         end
         exp_rdy = (softReset || prev_rst) ? 1'b0 : ~prev_pause;
         check("tx_tready", CW'(tx_tready), CW'(exp_rdy));
         if (!softReset && !prev_rst && !tx_tready) rdy_low_cnt++;
         prev_pause = pause_req;
         prev_rst = softReset;
         if (rx_tvalid) begin
            if (!in_pkt) begin
               first_cyc = cyc;
               if (end_valid) begin
                  gaps.push_back(cyc - end_cyc - 1);
                  check("rx_min_gap", CW'(cyc - end_cyc - 1 >= IPG), CW'(1));
               end
            end
            if (exp_q.size() == 0) begin
               check("rx_unexpected_beat", CW'(rx_tvalid), CW'(0));
            end else begin
               b = exp_q.pop_front();
               check("rx_tdata", CW'(rx_tdata), CW'(b.d));
               check("rx_tkeep", CW'(rx_tkeep), CW'(b.k));
               check("rx_tlast", CW'(rx_tlast), CW'(b.l));
            end
            in_pkt = ~rx_tlast;
            if (rx_tlast) begin
               end_valid = 1'b1;
               end_cyc = cyc;
            end
         end else begin
            check("rx_idle_zero", CW'({rx_tdata, rx_tkeep, rx_tlast}), {CW{1'b0}});
            if (in_pkt) begin
               check("rx_no_bubble", CW'(rx_tvalid), CW'(1));
               in_pkt = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_tready", CW'(tx_tready), CW'(0));
      check("reset_rx_tvalid", CW'(rx_tvalid), CW'(0));
      check("reset_rx_tdata", CW'(rx_tdata), CW'(0));
      check_counts("reset");
      softReset = 1'b0;

      // Single 4-beat packet: data and latency
      build_seq(4, 1);
      send_pkt(1'b0);
      wait_drain();
      check("t1_latency", CW'(first_cyc - tlast_cyc), CW'(2));
      check_counts("t1");

      // Three back-to-back packets: exact inter-packet gap
      gaps.delete();
      end_valid = 1'b0;
      for (int p = 0; p < 3; p++) begin
         build_seq(3, 16 + p * 3);
         send_pkt(1'b0);
      end
      wait_drain();
      check("t2_gap_count", CW'(gaps.size()), CW'(2));
      for (int i = 0; i < gaps.size(); i++) check("t2_gap_len", CW'(gaps[i]), CW'(IPG));
      check_counts("t2");

      // Oversized packet dropped, following packet intact
      build_seq(70, 100);
      send_pkt(1'b0);
      build_seq(2, 200);
      send_pkt(1'b0);
      wait_drain();
      check_counts("t3");

      // Errored packet dropped
      build_rand(2);
      send_pkt(1'b1);
      build_rand(2);
      send_pkt(1'b0);
      wait_drain();
      check_counts("t4");

      // Pause for 10 cycles mid-packet
      build_rand(20);
      rdy_low_cnt = 0;
      fork
         send_pkt(1'b0);
         begin
            repeat (4) @(posedge clk);
            #1;
            pause_req = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            pause_req = 1'b0;
         end
      join
      wait_drain();
      check("t5_ready_low_cycles", CW'(rdy_low_cnt), CW'(10));
      check_counts("t5");

      // Random packets with random pause and idle spacing
      rand_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 15; p++) begin
               build_rand($urandom_range(1, 8));
               send_pkt($urandom_range(0, 7) == 0);
               n = $urandom_range(0, 3);
               if (n > 0) begin
                  repeat (n) @(posedge clk);
                  #1;
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               pause_req = ($urandom_range(0, 4) == 0);
            end
            pause_req = 1'b0;
         end
      join
      wait_drain();
      check_counts("t6");

      // Reset during RX emission
      build_rand(30);
      send_pkt(1'b0);
      n = 0;
      while (!rx_tvalid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t7_rx_started", CW'(rx_tvalid), CW'(1));
      repeat (3) @(posedge clk);
      #1;
      softReset = 1'b1;
      exp_q.delete();
      fwd_exp = 0;
      drop_exp = 0;
      #1;
      check("t7_rst_rx_tvalid", CW'(rx_tvalid), CW'(0));
      check("t7_rst_tx_tready", CW'(tx_tready), CW'(0));
      check_counts("t7_rst");
      repeat (3) @(posedge clk);
      #1;
      softReset = 1'b0;
      build_rand(4);
      send_pkt(1'b0);
      wait_drain();
      check("t7_latency", CW'(first_cyc - tlast_cyc), CW'(2));
      check_counts("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ase_hssi_loopback_emul.md
Name: ase_hssi_loopback_emul

Overview:
- ASE-only HSSI traffic emulator; one instance per Ethernet channel in the simulation AFU wrapper.
- Consumes the AFU's HSSI TX AXI-S stream, buffers whole packets (store-and-forward) and replays them on the HSSI RX stream, which has no backpressure.
- Replaces the constant RX tie-off so AFU Ethernet paths are exercised in simulation; provides pause-driven TX backpressure and drop/packet counters.

Parameters:
- DATA_W, 512, TX/RX tdata width in bits; must be >=128 and a multiple of 8.
- DEPTH, 64, packet buffer depth in beats; power of 2.
- IPG_CYCLES, 2, idle cycles forced between emitted RX packets; 0 allowed.

Ports:
- clk  in  1  channel clock (i_hssi_clk_pll)
- softReset  in  1  asynchronous, active-high reset
- tx_tvalid  in  1  AFU TX beat valid
- tx_tready  out  1  emulator accepts TX beat
- tx_tdata  in  DATA_W  TX data
- tx_tkeep  in  DATA_W/8  TX byte enables
- tx_tlast  in  1  last beat of packet
- tx_tuser_err  in  1  client error; sampled on tlast beat
- pause_req  in  1  deasserts tx_tready while high
- rx_tvalid  out  1  RX beat valid (no ready)
- rx_tdata  out  DATA_W  RX data
- rx_tkeep  out  DATA_W/8  RX byte enables
- rx_tlast  out  1  RX last beat
- pkt_fwd_cnt  out  32  packets committed for replay
- pkt_drop_cnt  out  32  packets dropped

Behaviour:
- Single clock domain. One clock and one reset: softReset is asynchronous and active-high. While softReset is high all outputs are 0, except tx_tready, which is 0. All pointers, counters and FSMs clear.
- tx_tready = ~pause_req, registered (one-cycle delay from pause_req). A handshake is tx_tvalid & tx_tready.
- Buffer: DEPTH x (DATA_W + DATA_W/8 + 1) RAM with pointers wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits and wrapping naturally. Full when wr_ptr - rd_ptr == DEPTH.
- Input FSM, states ACCEPT and DISCARD:
  - ACCEPT, beat accepted, not full: write beat, wr_ptr++.
  - On the tlast beat with tuser_err=0: commit_ptr <= wr_ptr+1, pkt_fwd_cnt++, pkt_avail++.
  - On the tlast beat with tuser_err=1: wr_ptr <= commit_ptr, pkt_drop_cnt++.
  - ACCEPT, beat accepted while full: do not write; wr_ptr <= commit_ptr.
    - If that beat has tlast: pkt_drop_cnt++ and stay in ACCEPT.
    - Otherwise go to DISCARD.
  - DISCARD: accept and ignore beats. On tlast, pkt_drop_cnt++ and return to ACCEPT.
  - Packets longer than DEPTH beats are therefore always dropped.
- Output FSM, states IDLE, SEND, GAP:
  - IDLE: when pkt_avail != 0, issue RAM read at rd_ptr and go to SEND.
  - SEND: rx_tvalid=1 every cycle, one beat per cycle with no bubbles, rd_ptr++ per beat.
    - On the emitted tlast beat, pkt_avail--.
    - Then go to GAP if IPG_CYCLES>0; otherwise stay in SEND if pkt_avail (post-update) != 0, else IDLE.
  - GAP: count IPG_CYCLES cycles with rx_tvalid=0, then go to IDLE.
- Latency: if the output is IDLE and the TX tlast handshake occurs in cycle N, the first RX beat is valid in cycle N+2.
- Simultaneous commit and packet completion in one cycle leaves pkt_avail unchanged. pkt_avail is never read stale: the commit is visible the next cycle.
- The output never reads uncommitted beats (rd_ptr never passes commit_ptr).
- rx_tdata/rx_tkeep/rx_tlast are 0 whenever rx_tvalid=0.
- Counters wrap at 2^32.
- Reset mid-packet: partial input and output packets are lost. After deassertion, the first accepted beat starts a new packet.

Optional Feature:
- Macro HSSI_LB_MAC_SWAP_EN.
- Defined: on the first RX beat of each packet, bytes [5:0] (DA) and [11:6] (SA) of rx_tdata are swapped. The swap is applied on the output path, adds no latency, and other bytes and tkeep are unchanged.
- Undefined: data is replayed byte-exact.

Test Plan:
- 4-beat packet (tdata beats 0x1..0x4, tkeep all-ones), pause_req=0, IPG_CYCLES=2 -> RX beats 0x1..0x4 back-to-back, first beat at tlast cycle+2; pkt_fwd_cnt=1, pkt_drop_cnt=0.
- Three 3-beat packets sent back-to-back -> RX emits 3/gap2/3/gap2/3, data order preserved; pkt_fwd_cnt=3.
- 70-beat packet with DEPTH=64, then a 2-beat packet -> first packet absent on RX; pkt_drop_cnt=1; second packet replayed intact; pkt_fwd_cnt=1.
- 2-beat packet with tuser_err=1 on tlast, then a good 2-beat packet -> only the good packet appears on RX; pkt_drop_cnt=1, pkt_fwd_cnt=1.
- pause_req high for 10 cycles during a packet -> tx_tready low for those 10 cycles (1-cycle delayed); no beats lost; RX packet intact.
- softReset asserted mid-RX-emission for 3 cycles -> rx_tvalid=0, counters=0, tx_tready=0 immediately. A packet sent afterwards is replayed correctly. With HSSI_LB_MAC_SWAP_EN, first-beat bytes 0-5/6-11 are swapped.
